// File: rtl/cordic_lut_loader.sv
// LUT load master for the CORDIC core: streams ROM words into the
// core's write port, pulses the core reset and reports a checksum.
module cordic_lut_loader #(
  parameter int AW      = 6,
  parameter int DW      = 48,
  parameter int RST_CYC = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic          wen,
  output logic [AW-1:0] index_wri,
  output logic [DW-1:0] D,
  output logic          core_reset,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] checksum
);

  localparam int DEPTH = 2 ** AW;
  localparam int RW    = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    PREF,
    WRITE,
    CRST,
    DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] cnt;
  logic          last;
  logic [RW-1:0] rcnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rom_addr   <= '0;
      wen        <= 1'b1;
      index_wri  <= '0;
      D          <= '0;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      checksum   <= '0;
      cnt        <= '0;
      last       <= 1'b0;
      rcnt       <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= PREF;
            rom_addr <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            checksum <= '0;
            cnt      <= '0;
            last     <= 1'b0;
          end
        end
        PREF: begin
          rom_addr <= rom_addr + 1'b1;
          state    <= WRITE;
        end
        WRITE: begin
          // last is set on the final beat; the following edge closes out
          if (last) begin
            wen        <= 1'b1;
            index_wri  <= '0;
            core_reset <= 1'b0;
            rcnt       <= '0;
            state      <= CRST;
          end else begin
            wen       <= 1'b0;
            index_wri <= cnt;
            D         <= rom_data;
            checksum  <= checksum ^ rom_data;
            rom_addr  <= rom_addr + 1'b1;
            cnt       <= cnt + 1'b1;
            last      <= (cnt == AW'(DEPTH - 1));
          end
        end
        CRST: begin
          if (rcnt == RW'(RST_CYC - 1)) begin
            core_reset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
